keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
// Input-side counterpart of the 4-digit seven-segment display path. Scans a 4x4
// matrix keypad by driving one column low at a time and reading the rows.
// Debounces presses and emits a one-cycle Key_Valid strobe with a 4-bit key code.
// Shifts each accepted code into a 16-bit entry register; that register feeds the
// display data input and the ALU operand latch.
// PARAMETERS
// SCAN_DIV      100000  clock cycles per column dwell; SCAN_DIV >= 4 required
// DEBOUNCE_CNT  3       consecutive matching dwell samples to accept a press or release (>= 2)
// PORTS
// CLK        in   1   system clock (100 MHz)
// Reset      in   1   synchronous, active-high reset
// Row        in   4   keypad rows, active-low, pulled up externally, asynchronous
// Clear      in   1   synchronous clear of Data
// Col        out  4   column drive, active-low, exactly one bit low at all times
// Key_Code   out  4   last accepted key, {row_idx[1:0], col_idx[1:0]}
// Key_Valid  out  1   one-cycle strobe, asserted when Key_Code updates
// Key_Held   out  1   high from the accept cycle until release is accepted
// Data       out  16  entry register, newest code in Data[3:0]
// BEHAVIOUR
// - Reset, sampled on posedge CLK, sets: state=SCAN, col_idx=0, Col=4'b1110, Div=0,
//   Key_Code=0, Key_Valid=0, Key_Held=0, Data=0, synchronizer FFs=4'hF.
//   Reset mid-operation aborts any debounce or hold.
// - Row passes through a 2-FF synchronizer (Row_s). All decisions use Row_s.
// - Div counts 0..SCAN_DIV-1 and wraps. A "sample" is the cycle with Div==SCAN_DIV-1.
//   Col = ~(4'b1 << col_idx). Col is registered and changes only in the cycle after a sample.
// - Row_s is "single" when exactly one bit is 0; row_idx is the index of that bit.
//   All-high and multi-low patterns are not single.
// - SCAN: at each sample:
//   - Row_s single: latch cand={row_idx,col_idx}, hold col_idx, set match=1, go DEBOUNCE.
//   - Otherwise: col_idx <= col_idx+1, wrapping 3->0.
// - DEBOUNCE: col_idx frozen. At each sample:
//   - Row_s single with the same row_idx: match++.
//     When match reaches DEBOUNCE_CNT: Key_Code<=cand, Key_Valid=1 for the next cycle only,
//     Key_Held<=1, rel=0, go HELD.
//   - Any other pattern: go SCAN and advance col_idx. No strobe.
// - HELD: col_idx frozen. At each sample:
//   - Row_s all-high: rel++. When rel reaches DEBOUNCE_CNT: Key_Held<=0, go SCAN, advance col_idx.
//   - Any low row: rel=0.
//   - Key_Valid is never repeated while held. No auto-repeat.
// - Press latency: Key_Valid rises 1 cycle after the DEBOUNCE_CNT-th matching sample.
//   The worst case from a stable press is 2 + 4*SCAN_DIV + (DEBOUNCE_CNT-1)*SCAN_DIV cycles.
// - Data, in the cycle Key_Valid is high: Data <= {Data[11:0], Key_Code}. The oldest nibble is dropped.
// - Clear sets Data=0 next cycle. It does not affect the scanner state.
//   Clear coincident with the Key_Valid cycle: Clear wins and the code is not shifted in.
//   Key_Valid and Key_Code still update.
// - Keys pressed in other columns while DEBOUNCE or HELD are ignored.
//   They are only seen after scanning resumes.
// - Reset while a key is physically held: the scanner restarts in SCAN.
//   The held key is re-detected and produces a fresh Key_Valid.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=3)
// 1 Reset, idle Row=4'hF for 64 cycles -> Col cycles 1110,1101,1011,0111 every 4 clocks;
//   Key_Valid never 1; Data=0.
// 2 Hold row2/col1 low steady -> exactly one Key_Valid, Key_Code=4'h9, Data=16'h0009;
//   Key_Held stays 1 until release plus 3 samples.
// 3 Press/release keys with codes 1,2,3,4,5 in turn -> Data=16'h2345 after the 5th strobe;
//   Clear then gives Data=0.
// 4 Bounce: row0/col0 low for 1 sample, high next, repeated -> no Key_Valid;
//   scanning resumes at col1.
// 5 Rows 0 and 3 low together in col2 -> no Key_Valid.
//   Release row3 -> Key_Code=4'h2 after 3 samples.
// 6 Assert Reset during HELD with key still low -> Col=1110, Data=0, Key_Held=0 next cycle.
//   Key re-accepted with a single new strobe.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: raw rows, clear request, column drive and the accepted-key outputs.
// The scanner takes the slave view; whatever drives the keypad takes the master view.
interface keypad_scanner_if;
    logic [3:0]  Row;
    logic        Clear;
    logic [3:0]  Col;
    logic [3:0]  Key_Code;
    logic        Key_Valid;
    logic        Key_Held;
    logic [15:0] Data;

    modport master (
        output Row,
        output Clear,
        input  Col,
        input  Key_Code,
        input  Key_Valid,
        input  Key_Held,
        input  Data
    );

    modport slave (
        input  Row,
        input  Clear,
        output Col,
        output Key_Code,
        output Key_Valid,
        output Key_Held,
        output Data
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one column driven low per dwell, debounced press/release,
// one-cycle strobe per accepted key and a 4-nibble entry shift register.
module keypad_scanner #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic            CLK,
    input  logic            Reset,
    keypad_scanner_if.slave kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // Counters are compared before incrementing, so the last matching sample sees CNT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t           state;
    logic [3:0]       row_meta;
    logic [3:0]       row_s;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic [3:0]       cand;
    logic [CNT_W-1:0] match;
    logic [CNT_W-1:0] rel;

    logic             sample;
    logic             single;
    logic [1:0]       row_idx;
    logic [1:0]       next_col;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // NOTE: every signal written here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        single  = 1'b0;
        row_idx = 2'd0;
        unique case (row_s)
            4'b1110: begin single = 1'b1; row_idx = 2'd0; end
            4'b1101: begin single = 1'b1; row_idx = 2'd1; end
            4'b1011: begin single = 1'b1; row_idx = 2'd2; end
            4'b0111: begin single = 1'b1; row_idx = 2'd3; end
            default: begin single = 1'b0; row_idx = 2'd0; end
        endcase
        sample   = (div == DIV_LAST);
        next_col = col_idx + 2'd1;
    end

    // NOTE: all state below is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= SCAN;
            row_meta     <= 4'hF;
            row_s        <= 4'hF;
            div          <= '0;
            col_idx      <= 2'd0;
            cand         <= 4'd0;
            match        <= '0;
            rel          <= '0;
            kp.Col       <= 4'b1110;
            kp.Key_Code  <= 4'd0;
            kp.Key_Valid <= 1'b0;
            kp.Key_Held  <= 1'b0;
            kp.Data      <= 16'd0;
        end else begin
            row_meta     <= kp.Row;
            row_s        <= row_meta;
            kp.Key_Valid <= 1'b0;
            div          <= sample ? '0 : div + 1'b1;

            // Clear beats a coincident shift; the strobe and code are unaffected.
            if (kp.Clear) begin
                kp.Data <= 16'd0;
            end else if (kp.Key_Valid) begin
                kp.Data <= {kp.Data[11:0], kp.Key_Code};
            end

            if (sample) begin
                unique case (state)
                    SCAN: begin
                        if (single) begin
                            cand  <= {row_idx, col_idx};
                            match <= CNT_W'(1);
                            state <= DEBOUNCE;
                        end else begin
                            col_idx <= next_col;
                            kp.Col  <= col_drive(next_col);
                        end
                    end
                    DEBOUNCE: begin
                        if (single && (row_idx == cand[3:2])) begin
                            if (match == CNT_LAST) begin
                                kp.Key_Code  <= cand;
                                kp.Key_Valid <= 1'b1;
                                kp.Key_Held  <= 1'b1;
                                rel          <= '0;
                                state        <= HELD;
                            end else begin
                                match <= match + 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= next_col;
                            kp.Col  <= col_drive(next_col);
                        end
                    end
                    HELD: begin
                        if (row_s == 4'hF) begin
                            if (rel == CNT_LAST) begin
                                kp.Key_Held <= 1'b0;
                                state       <= SCAN;
                                col_idx     <= next_col;
                                kp.Col      <= col_drive(next_col);
                            end else begin
                                rel <= rel + 1'b1;
                            end
                        end else begin
                            rel <= '0;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives the rows from the live column drive,
// directed vectors cover the documented scenarios, random presses are scored against a shift model.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int PRESS_BOUND  = 2 + 4 * SCAN_DIV + (DEBOUNCE_CNT - 1) * SCAN_DIV + 6;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .kp   (kif)
    );

    always #5 CLK = ~CLK;

    // Pressed keys, bit r*4+c; a pressed key pulls its row low while its column is driven low.
    logic [15:0] keys = 16'd0;

    always_comb begin
        kif.Row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (|(keys[r*4 +: 4] & ~kif.Col)) kif.Row[r] = 1'b0;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Cycles since reset release, used to know where the dwell boundaries fall.
    int since_rst = 0;
    always @(posedge CLK) since_rst <= Reset ? 0 : since_rst + 1;

    int         strobe_cnt = 0;
    int         double_cnt = 0;
    int         bad_col    = 0;
    logic [3:0] last_code  = 4'd0;
    logic       prev_valid = 1'b0;

    always @(negedge CLK) begin
        if (kif.Key_Valid) begin
            strobe_cnt++;
            last_code = kif.Key_Code;
            if (prev_valid) double_cnt++;
        end
        prev_valid = kif.Key_Valid;
        if ($countones(~kif.Col) != 1) bad_col++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int n);
        @(negedge CLK);
        Reset = 1'b1;
        repeat (n) @(negedge CLK);
        Reset = 1'b0;
    endtask

    // Advance to the negedge right after the next dwell-end edge.
    task automatic wait_sample();
        do @(negedge CLK); while (since_rst % SCAN_DIV != 0);
    endtask

    task automatic press_key(input int r, input int c, input int hold,
                             output int n, output logic [3:0] code);
        int start;
        start = strobe_cnt;
        keys[r*4 + c] = 1'b1;
        repeat (hold) @(negedge CLK);
        n    = strobe_cnt - start;
        code = last_code;
    endtask

    task automatic release_key(input int r, input int c, input string name);
        int k;
        keys[r*4 + c] = 1'b0;
        k = 0;
        while (kif.Key_Held && k < 30) begin
            @(negedge CLK);
            k++;
        end
        check({name, "_release"}, kif.Key_Held, 1'b0);
    endtask

    task automatic pulse_clear();
        @(negedge CLK);
        kif.Clear = 1'b1;
        @(negedge CLK);
        kif.Clear = 1'b0;
    endtask

    typedef struct {
        int          r;
        int          c;
        logic [3:0]  code;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          n;
        int          start;
        int          k;
        logic [3:0]  code;
        logic [15:0] exp_data;

        vecs[0] = '{r: 2, c: 1, code: 4'h9, data: 16'h0009};
        vecs[1] = '{r: 0, c: 1, code: 4'h1, data: 16'h0091};
        vecs[2] = '{r: 0, c: 2, code: 4'h2, data: 16'h0912};
        vecs[3] = '{r: 0, c: 3, code: 4'h3, data: 16'h9123};
        vecs[4] = '{r: 1, c: 0, code: 4'h4, data: 16'h1234};
        vecs[5] = '{r: 1, c: 1, code: 4'h5, data: 16'h2345};

        kif.Clear = 1'b0;
        do_reset(3);

        check("reset_col", kif.Col, 4'b1110);
        check("reset_code", kif.Key_Code, 4'h0);
        check("reset_valid", kif.Key_Valid, 1'b0);
        check("reset_held", kif.Key_Held, 1'b0);
        check("reset_data", kif.Data, 16'h0000);

        // Idle scan: columns rotate once per dwell.
        for (int i = 0; i < 64; i++) begin
            logic [3:0] exp_col;
            @(negedge CLK);
            exp_col = ~(4'b0001 << ((since_rst / SCAN_DIV) % 4));
            check("idle_col", kif.Col, exp_col);
        end
        check("idle_strobes", strobe_cnt, 0);
        check("idle_data", kif.Data, 16'h0000);

        // Directed key sequence: 9 then 1..5.
        for (int i = 0; i < 6; i++) begin
            press_key(vecs[i].r, vecs[i].c, 60, n, code);
            check("vec_strobes", n, 1);
            check("vec_code", code, vecs[i].code);
            check("vec_data", kif.Data, vecs[i].data);
            check("vec_held", kif.Key_Held, 1'b1);
            if (i == 0) begin
                keys[vecs[i].r*4 + vecs[i].c] = 1'b0;
                repeat (8) @(negedge CLK);
                check("held_after_release", kif.Key_Held, 1'b1);
            end
            release_key(vecs[i].r, vecs[i].c, "vec");
            repeat (5) @(negedge CLK);
        end
        pulse_clear();
        check("clear_data", kif.Data, 16'h0000);

        // Bounce on row0/col0: detected, lost on the next sample, scanning moves to col1.
        do_reset(2);
        start = strobe_cnt;
        for (int i = 0; i < 3; i++) begin
            keys[0] = 1'b1;
            wait_sample();
            keys[0] = 1'b0;
            wait_sample();
            check("bounce_col", kif.Col, 4'b1101);
            repeat (3) wait_sample();
            check("bounce_back_col0", kif.Col, 4'b1110);
        end
        check("bounce_strobes", strobe_cnt - start, 0);
        check("bounce_held", kif.Key_Held, 1'b0);

        // Two rows low in one column is ambiguous; releasing one leaves a single key.
        start = strobe_cnt;
        keys[0*4 + 2] = 1'b1;
        keys[3*4 + 2] = 1'b1;
        repeat (64) @(negedge CLK);
        check("multi_strobes", strobe_cnt - start, 0);
        keys[3*4 + 2] = 1'b0;
        k = 0;
        while (strobe_cnt == start && k < PRESS_BOUND) begin
            @(negedge CLK);
            k++;
        end
        check("multi_timeout", (k < PRESS_BOUND), 1'b1);
        check("multi_code", last_code, 4'h2);
        repeat (2) @(negedge CLK);
        check("multi_data", kif.Data, 16'h0002);
        release_key(0, 2, "multi");

        // Reset while held: outputs cleared, the same key is re-accepted once.
        press_key(1, 2, 60, n, code);
        check("pre_reset_code", code, 4'h6);
        check("pre_reset_data", kif.Data, 16'h0026);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        check("rst_held_col", kif.Col, 4'b1110);
        check("rst_held_data", kif.Data, 16'h0000);
        check("rst_held_held", kif.Key_Held, 1'b0);
        start = strobe_cnt;
        repeat (60) @(negedge CLK);
        check("reaccept_strobes", strobe_cnt - start, 1);
        check("reaccept_code", last_code, 4'h6);
        check("reaccept_data", kif.Data, 16'h0006);
        release_key(1, 2, "reaccept");

        // Clear held across the accept: strobe and code update, Data stays empty.
        kif.Clear = 1'b1;
        press_key(3, 3, 50, n, code);
        check("clr_coinc_strobes", n, 1);
        check("clr_coinc_code", code, 4'hF);
        check("clr_coinc_keycode", kif.Key_Code, 4'hF);
        check("clr_coinc_data", kif.Data, 16'h0000);
        kif.Clear = 1'b0;
        release_key(3, 3, "clr_coinc");

        // Random presses scored against a nibble-shift model of the entry register.
        exp_data = 16'h0000;
        for (int i = 0; i < 14; i++) begin
            int          r;
            int          c;
            logic [3:0]  exp_code;
            r        = int'($urandom_range(0, 3));
            c        = int'($urandom_range(0, 3));
            exp_code = 4'(r * 4 + c);
            press_key(r, c, int'($urandom_range(40, 80)), n, code);
            exp_data = {exp_data[11:0], exp_code};
            check("rand_strobes", n, 1);
            check("rand_code", code, exp_code);
            check("rand_data", kif.Data, exp_data);
            release_key(r, c, "rand");
            repeat ($urandom_range(0, 20)) @(negedge CLK);
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
                exp_data = 16'h0000;
                check("rand_clear", kif.Data, exp_data);
            end
        end

        check("strobe_width", double_cnt, 0);
        check("col_one_low", bad_col, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
